hi_lo_multiply_divide_unit: RTL and testbench
=============================================

# hi_lo_multiply_divide_unit

Execute-stage multiply/divide unit that directly consumes the Decode/Execute pipeline register outputs (`hi_lo_register_write_execute`, `ALU_function_execute`, and the forwarded operands) and owns the architectural HI and LO registers. It executes MULT/MULTU/DIV/DIVU iteratively and MTHI/MTLO in one cycle. HI and LO are presented continuously to the execute-stage result mux for MFHI/MFLO. A busy flag goes to the hazard unit, which stalls any following HI/LO access until the operation completes.

## Interface
Parameters:
- `ITERATIONS`, 32: iteration count for the iterative datapath; fixed to the operand width.

Ports:
- `clk`  input  1: clock; all state updates on the rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `start`  input  1: driven by `hi_lo_register_write_execute`; the instruction in execute writes HI/LO.
- `function_code`  input  6: `ALU_function_execute`. Codes: 0x11 MTHI, 0x13 MTLO, 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU.
- `operand_a`  input  32: rs value after forwarding.
- `operand_b`  input  32: rt value after forwarding.
- `busy`  output  1: an iterative operation is in progress.
- `hi`  output  32: architectural HI.
- `lo`  output  32: architectural LO.

## Operation
- Reset: `hi`=0, `lo`=0, `busy`=0, state IDLE, iteration counter=0.
- States:
  - IDLE: accepts work.
  - MUL: shift-add, 1 bit per cycle.
  - DIV: restoring, 1 quotient bit per cycle.
- Accept condition: `start`=1 in IDLE with a valid code. `start`=1 with any other code is ignored.
- While not IDLE, `start` is ignored. The hazard unit guarantees it is held off.
- MTHI: `hi`<=`operand_a` at the accept edge. MTLO: `lo`<=`operand_a` at the accept edge. State stays IDLE.
- Signed setup (MULT, DIV):
  - Operands are converted to magnitudes at accept.
  - Result sign flags are latched: product/quotient sign = a[31]^b[31]; remainder sign = a[31].
  - Final results are negated in two's complement on completion when the flag is set.
- Unsigned ops (MULTU, DIVU) use the operands directly.
- Multiply: {hi,lo} = 64-bit product, truncated to no bits.
- Divide: `lo` = quotient, `hi` = remainder.
  - The remainder has the dividend's sign.
  - The quotient truncates toward zero.
- Divide by zero: `lo`=0xFFFFFFFF, `hi`=`operand_a` unmodified, for both signed and unsigned.
- DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- HI/LO change only at the completion edge. Intermediate values live in internal accumulators; `hi`/`lo` hold old values while busy.

## Timing
- MTHI/MTLO: 1 cycle. The new value is visible on `hi`/`lo` the cycle after the accept edge. `busy` is never asserted.
- Iterative ops:
  - Accept edge E0: `busy` rises after E0.
  - Edges E1..E32: iterations run.
  - At E32: `hi`/`lo` are written and `busy` falls. Results are visible in the cycle following E32.
  - `busy` is high for exactly 32 cycles.
- Divide by zero still takes 32 cycles. Early termination is not permitted, so timing is data-independent.
- Back-to-back: a new `start` in the first cycle with `busy`=0 after completion is accepted normally.
- Reset mid-operation: at the reset edge, state goes to IDLE, `busy`=0, and `hi`/`lo`=0. The partial result is discarded.
- Reset wins over a simultaneous `start`.

## Configuration
- `MDU_SINGLE_CYCLE_MULT_EN` defined: MULT/MULTU use a combinational 32x32 multiplier.
  - {hi,lo} is written at the accept edge and `busy` is never asserted for multiplies.
  - The MUL state is not compiled.
- Not defined: multiplies use the iterative MUL state with the 32-cycle timing above.
- Divide is always iterative.

## Test plan
- Reset, then MTHI 0x12345678 and the next cycle MTLO 0xCAFEBABE -> `hi`=0x12345678, `lo`=0xCAFEBABE, `busy` never high.
- MULT 0xFFFFFFFE × 0x00000003 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. Latency is 32 cycles without the macro and 1 cycle with it.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001.
- DIV -7 / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 100 / 7 -> `lo`=14, `hi`=2. `busy` is high exactly 32 cycles each.
- DIVU 5 / 0 -> `lo`=0xFFFFFFFF, `hi`=5 after 32 cycles. DIV 0x80000000 / -1 -> `lo`=0x80000000, `hi`=0.
- Start DIVU, assert `reset` at cycle 10 and `start` MTLO during `busy`:
  - `busy`=0 and `hi`=`lo`=0 after the reset edge.
  - A `start` while busy leaves HI/LO unchanged.

Source files
------------

// File: rtl/hi_lo_multiply_divide_unit.sv
// hi_lo_multiply_divide_unit: execute-stage iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO, owning architectural HI/LO
//   clk, reset (sync, active-high); start/function_code/operand_a/operand_b from the D/E register;
//   busy to the hazard unit; hi/lo to the execute result mux.
//   Optional MDU_SINGLE_CYCLE_MULT_EN: combinational multiplier, multiplies complete at the accept edge.
module hi_lo_multiply_divide_unit #(
  parameter int ITERATIONS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  function_code,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam logic [5:0] F_MTHI = 6'h11, F_MTLO = 6'h13, F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
`ifdef MDU_SINGLE_CYCLE_MULT_EN
  typedef enum logic [1:0] {IDLE, DIV} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
`endif
  state_t      state;
  logic [5:0]  cnt;
  logic [63:0] acc;
  logic [31:0] opnd, dz_a;
  logic        neg_q, neg_r, dz;
  logic        is_signed, sign_q, last, is_mul, is_div;
  logic [31:0] mag_a, mag_b, div_sub, quo, rmd;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [63:0] div_next;
  assign is_signed = function_code == F_MULT || function_code == F_DIV;
  assign is_mul = function_code == F_MULT || function_code == F_MULTU;
  assign is_div = function_code == F_DIV || function_code == F_DIVU;
  assign sign_q = is_signed && (operand_a[31] ^ operand_b[31]);
  assign mag_a = is_signed && operand_a[31] ? -operand_a : operand_a;
  assign mag_b = is_signed && operand_b[31] ? -operand_b : operand_b;
  assign last = cnt == 6'(ITERATIONS - 1);
  assign busy = state != IDLE;
  // Restoring division: acc = {partial remainder, dividend shifting out / quotient shifting in}.
  // When the trial subtract succeeds the true difference is < 2^32, so 32-bit wraparound is exact.
  assign div_shift = {acc[63:32], acc[31]};
  assign div_ge = div_shift >= {1'b0, opnd};
  assign div_sub = div_shift[31:0] - opnd;
  assign div_next = {div_ge ? div_sub : div_shift[31:0], acc[30:0], div_ge};
  assign quo = neg_q ? -div_next[31:0] : div_next[31:0];
  assign rmd = neg_r ? -div_next[63:32] : div_next[63:32];
`ifdef MDU_SINGLE_CYCLE_MULT_EN
  logic [63:0] prod_mag, prod;
  assign prod_mag = {32'd0, mag_a} * {32'd0, mag_b};
  assign prod = sign_q ? -prod_mag : prod_mag;
`else
  // Shift-add: acc = {partial product, multiplier shifting out}; the carry re-enters at the top.
  logic [32:0] mul_sum;
  logic [63:0] mul_next, mul_res;
  assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign mul_next = {mul_sum, acc[31:1]};
  assign mul_res = neg_q ? -mul_next : mul_next;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      opnd <= '0;
      dz_a <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        if (function_code == F_MTHI) hi <= operand_a;
        if (function_code == F_MTLO) lo <= operand_a;
        if (is_div) begin
          state <= DIV;
          cnt <= '0;
          acc <= {32'd0, mag_a};
          opnd <= mag_b;
          neg_q <= sign_q;
          neg_r <= is_signed && operand_a[31];
          dz <= operand_b == 32'd0;
          dz_a <= operand_a;
        end
`ifdef MDU_SINGLE_CYCLE_MULT_EN
        if (is_mul) {hi, lo} <= prod;
`else
        if (is_mul) begin
          state <= MUL;
          cnt <= '0;
          acc <= {32'd0, mag_b};
          opnd <= mag_a;
          neg_q <= sign_q;
        end
`endif
      end
    end else begin
      cnt <= last ? '0 : cnt + 6'd1;
      if (last) state <= IDLE;
`ifndef MDU_SINGLE_CYCLE_MULT_EN
      if (state == MUL) begin
        acc <= mul_next;
        if (last) {hi, lo} <= mul_res;
      end
`endif
      if (state == DIV) begin
        acc <= div_next;
        if (last) begin
          hi <= dz ? dz_a : rmd;
          lo <= dz ? 32'hFFFF_FFFF : quo;
        end
      end
    end
  end
endmodule

// File: tb/tb_hi_lo_multiply_divide_unit.sv
// tb_hi_lo_multiply_divide_unit: arithmetic reference model with per-cycle compare plus directed literal checks
module tb_hi_lo_multiply_divide_unit;
  logic clk = 0, reset = 1, start = 0;
  logic [5:0] function_code = '0;
  logic [31:0] operand_a = '0, operand_b = '0;
  logic busy;
  logic [31:0] hi, lo;
  int vectors = 0, miscompares = 0;
  int m_cnt = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
`ifdef MDU_SINGLE_CYCLE_MULT_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 32;
`endif
  always #5 clk = ~clk;
  hi_lo_multiply_divide_unit dut (
    .clk(clk), .reset(reset), .start(start), .function_code(function_code),
    .operand_a(operand_a), .operand_b(operand_b), .busy(busy), .hi(hi), .lo(lo)
  );
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    if ((f == 6'h1A || f == 6'h1B) && b == 32'd0) return {a, 32'hFFFF_FFFF};
    case (f)
      6'h18: return sa * sb;
      6'h19: return ua * ub;
      6'h1A: return {32'(sa % sb), 32'(sa / sb)};
      6'h1B: return {32'(ua % ub), 32'(ua / ub)};
      default: return '0;
    endcase
  endfunction
  always @(posedge clk) begin
    if (reset) begin
      m_hi = '0;
      m_lo = '0;
      m_cnt = 0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (start) begin
      if (function_code == 6'h11) m_hi = operand_a;
      else if (function_code == 6'h13) m_lo = operand_a;
      else if (function_code inside {6'h18, 6'h19, 6'h1A, 6'h1B}) begin
        {p_hi, p_lo} = model(function_code, operand_a, operand_b);
        m_cnt = function_code <= 6'h19 ? MUL_LAT : 32;
        if (m_cnt == 0) begin
          m_hi = p_hi;
          m_lo = p_lo;
        end
      end
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    check("model busy", {31'd0, busy}, {31'd0, m_cnt > 0});
    check("model hi", hi, m_hi);
    check("model lo", lo, m_lo);
  end
  task automatic op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] eh, input logic [31:0] el, input int elat, input string name, input bit now = 0);
    int n = 0;
    if (!now) @(negedge clk);
    function_code = f;
    operand_a = a;
    operand_b = b;
    start = 1;
    @(negedge clk);
    start = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check({name, " busy cycles"}, 32'(n), 32'(elat));
    check({name, " hi"}, hi, eh);
    check({name, " lo"}, lo, el);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    reset = 0;
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    check("reset busy", {31'd0, busy}, 32'h0);
    op(6'h11, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'h0, 0, "mthi");
    op(6'h13, 32'hCAFE_BABE, 32'h0, 32'h1234_5678, 32'hCAFE_BABE, 0, "mtlo");
    op(6'h18, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT, "mult neg");
    op(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, MUL_LAT, "multu max");
    op(6'h18, 32'h7, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD, MUL_LAT, "mult 7x-5");
    op(6'h1A, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32, "div -7/2");
    op(6'h1A, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 32, "div 7/-2");
    op(6'h1B, 32'd100, 32'd7, 32'd2, 32'd14, 32, "divu 100/7");
    op(6'h1B, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 32, "divu by zero");
    op(6'h1A, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32, "div by zero");
    op(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32, "div overflow");
    op(6'h20, 32'h1111_1111, 32'h2, 32'h0, 32'h8000_0000, 0, "invalid code");
    op(6'h1B, 32'd100, 32'd7, 32'd2, 32'd14, 32, "divu b2b first");
    op(6'h19, 32'd3, 32'd4, 32'd0, 32'd12, MUL_LAT, "multu b2b second", 1);
    @(negedge clk);
    function_code = 6'h1B;
    operand_a = 32'd1000;
    operand_b = 32'd3;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    function_code = 6'h13;
    operand_a = 32'hDEAD_BEEF;
    start = 1;
    @(negedge clk);
    start = 0;
    check("start while busy lo", lo, 32'd12);
    check("start while busy busy", {31'd0, busy}, 32'h1);
    repeat (4) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("mid reset busy", {31'd0, busy}, 32'h0);
    check("mid reset hi", hi, 32'h0);
    check("mid reset lo", lo, 32'h0);
    op(6'h13, 32'h0000_0042, 32'h0, 32'h0, 32'h42, 0, "mtlo after reset");
    @(negedge clk);
    reset = 1;
    function_code = 6'h11;
    operand_a = 32'h5555_5555;
    start = 1;
    @(negedge clk);
    reset = 0;
    start = 0;
    check("reset beats start hi", hi, 32'h0);
    check("reset beats start lo", lo, 32'h0);
    op(6'h1B, 32'd1000, 32'd3, 32'd1, 32'd333, 32, "divu after reset");
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
